// File: rtl/dcache_responder_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// The line byte-enable helper widens a word enable to its lane inside a line.
package dcache_types;

  localparam int S_OFFSET     = 5;
  localparam int S_INDEX      = 3;
  localparam int S_TAG        = 32 - S_OFFSET - S_INDEX;
  localparam int S_LINE       = 8 << S_OFFSET;
  localparam int S_LINE_BYTES = S_LINE / 8;
  localparam int S_WORDS      = S_LINE / 32;
  localparam int S_SETS       = 1 << S_INDEX;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

  function automatic logic [S_LINE_BYTES-1:0] line_byte_enable(
    input logic [3:0]            be,
    input logic [S_OFFSET-3:0]   word
  );
    return S_LINE_BYTES'(be) << {word, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// Pipeline-side and memory-side ports of the data cache.
// Both sides use request/response: the requester holds its strobe and payload
// stable until the one-cycle resp pulse; the transfer completes on that cycle.
interface dcache_mem_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp
  );
  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

interface dcache_pmem_if;
  import dcache_types::*;
  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [S_LINE-1:0] pmem_wdata;
  logic [S_LINE-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/dcache_responder_array.sv
// Per-set storage: asynchronous read, synchronous byte-masked write.
// ASYNC_RST clears every entry on reset (used for the valid and dirty bits).
module dcache_array #(
  parameter  int WIDTH     = 32,
  parameter  int DEPTH     = 8,
  parameter  bit ASYNC_RST = 1'b0,
  localparam int AW        = $clog2(DEPTH),
  localparam int BW        = (WIDTH + 7) / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [BW-1:0]    be,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] bit_mask;

  for (genvar i = 0; i < WIDTH; i++) begin : g_mask
    assign bit_mask[i] = be[i/8];
  end

  assign rdata = mem[addr];

  if (ASYNC_RST) begin : g_rst
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
      end else if (we) begin
        mem[addr] <= (mem[addr] & ~bit_mask) | (wdata & bit_mask);
      end
    end
  end else begin : g_norst
    logic unused_rst;
    assign unused_rst = rst;
    always_ff @(posedge clk) begin
      if (we) mem[addr] <= (mem[addr] & ~bit_mask) | (wdata & bit_mask);
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage
// and a 256-bit line memory. Hits answer in the request cycle.
module dcache_responder
  import dcache_types::*;
(
  input  logic          clk,
  input  logic          rst,
  dcache_mem_if.slave   mem,
  dcache_pmem_if.master pmem,
  output state_t        dbg_state
);

  state_t                  state, next_state;
  logic [S_TAG-1:0]        req_tag, miss_tag, tag_rd;
  logic [S_INDEX-1:0]      req_index, miss_index, arr_index;
  logic [S_OFFSET-3:0]     req_word;
  logic                    req, hit, valid_rd, dirty_rd;
  logic [S_LINE-1:0]       line_rd, data_wdata;
  logic [S_LINE_BYTES-1:0] data_be;
  logic                    data_we, tag_we, valid_we, dirty_we, dirty_wdata;
  logic                    unused_addr_bits;

  assign req_tag          = mem.mem_address[31 -: S_TAG];
  assign req_index        = mem.mem_address[S_OFFSET +: S_INDEX];
  assign req_word         = mem.mem_address[2 +: S_OFFSET-2];
  assign unused_addr_bits = ^mem.mem_address[1:0];
  assign req              = mem.mem_read | mem.mem_write;
  assign dbg_state        = state;

  // Outside CHECK the arrays follow the latched miss set, so a withdrawn or
  // changed request cannot redirect an in-flight line transfer.
  assign arr_index = (state == CHECK) ? req_index : miss_index;
  assign hit       = valid_rd && (tag_rd == req_tag);

  dcache_array #(.WIDTH(S_LINE), .DEPTH(S_SETS)) u_data (
    .clk(clk), .rst(rst), .we(data_we), .addr(arr_index), .be(data_be),
    .wdata(data_wdata), .rdata(line_rd)
  );
  dcache_array #(.WIDTH(S_TAG), .DEPTH(S_SETS)) u_tag (
    .clk(clk), .rst(rst), .we(tag_we), .addr(arr_index), .be('1),
    .wdata(miss_tag), .rdata(tag_rd)
  );
  dcache_array #(.WIDTH(1), .DEPTH(S_SETS), .ASYNC_RST(1'b1)) u_valid (
    .clk(clk), .rst(rst), .we(valid_we), .addr(arr_index), .be(1'b1),
    .wdata(1'b1), .rdata(valid_rd)
  );
  dcache_array #(.WIDTH(1), .DEPTH(S_SETS), .ASYNC_RST(1'b1)) u_dirty (
    .clk(clk), .rst(rst), .we(dirty_we), .addr(arr_index), .be(1'b1),
    .wdata(dirty_wdata), .rdata(dirty_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CHECK;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_tag   <= '0;
      miss_index <= '0;
    end else if (state == CHECK && req && !hit) begin
      miss_tag   <= req_tag;
      miss_index <= req_index;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      CHECK:     if (req && !hit) next_state = dirty_rd ? WRITEBACK : FETCH;
      WRITEBACK: if (pmem.pmem_resp) next_state = req ? FETCH : CHECK;
      FETCH:     if (pmem.pmem_resp) next_state = CHECK;
      default:   next_state = CHECK;
    endcase
  end

  always_comb begin
    mem.mem_resp      = 1'b0;
    mem.mem_rdata     = '0;
    pmem.pmem_read    = 1'b0;
    pmem.pmem_write   = 1'b0;
    pmem.pmem_address = '0;
    pmem.pmem_wdata   = '0;
    data_we           = 1'b0;
    data_be           = '0;
    data_wdata        = '0;
    tag_we            = 1'b0;
    valid_we          = 1'b0;
    dirty_we          = 1'b0;
    dirty_wdata       = 1'b0;
    unique case (state)
      CHECK: begin
        if (req && hit) begin
          mem.mem_resp  = 1'b1;
          mem.mem_rdata = line_rd[{req_word, 5'b0} +: 32];
          // A write wins over a simultaneous read; a zero enable still dirties.
          if (mem.mem_write) begin
            data_we     = 1'b1;
            data_be     = line_byte_enable(mem.mem_byte_enable, req_word);
            data_wdata  = {S_WORDS{mem.mem_wdata}};
            dirty_we    = 1'b1;
            dirty_wdata = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        pmem.pmem_write   = 1'b1;
        pmem.pmem_address = {tag_rd, miss_index, {S_OFFSET{1'b0}}};
        pmem.pmem_wdata   = line_rd;
        if (pmem.pmem_resp) dirty_we = 1'b1;
      end
      FETCH: begin
        pmem.pmem_read    = 1'b1;
        pmem.pmem_address = {miss_tag, miss_index, {S_OFFSET{1'b0}}};
        if (pmem.pmem_resp) begin
          data_we    = 1'b1;
          data_be    = '1;
          data_wdata = pmem.pmem_rdata;
          tag_we     = 1'b1;
          valid_we   = 1'b1;
          dirty_we   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  a_rd_wr_excl: assert property (@(posedge clk) disable iff (rst)
    !(mem.mem_read && mem.mem_write));
  a_pmem_excl: assert property (@(posedge clk) disable iff (rst)
    !(pmem.pmem_read && pmem.pmem_write));

endmodule
